floor_request_queue: RTL and testbench

FLOOR_REQUEST_QUEUE -- requirements
Module: floor_request_queue

---
 rtl/floor_request_queue.sv | 152 +++++++++++++++
 tb/tb_floor_request_queue.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/floor_request_queue.sv
// floor_request_queue: debounced floor-call buttons feeding a 4-deep request FIFO.
// Optional macro FLOOR_REQ_DEDUP_EN drops calls for floors that are already queued.
module floor_request_queue #(
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    output logic [1:0] req_floor,
    output logic       req_valid,
    input  logic       req_ready,
    output logic [3:0] pending,
    output logic       overflow
);
    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    deb_q, deb_d;
    logic [3:0]    press_q, press_d;
    logic [3:0]    latch_q, latch_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];

    logic          wr_vld_q, wr_vld_d;
    logic [1:0]    wr_floor_q, wr_floor_d;

    logic [1:0]    mem_q [4];
    logic [1:0]    mem_d [4];
    logic [1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [2:0]    count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          pick_any;
    logic [1:0]    pick_floor;
    logic [3:0]    pick_mask;
    logic          pop, push, accept;

    // The counter holds the number of consecutive disagreeing cycles minus one.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        press_d = deb_d & ~deb_q;
    end

    // Descending scan so the lowest latched floor is the one selected.
    always_comb begin
        pick_any   = 1'b0;
        pick_floor = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (latch_q[i]) begin
                pick_any   = 1'b1;
                pick_floor = 2'(i);
            end
        end
        pick_mask  = pick_any ? (4'b0001 << pick_floor) : 4'b0000;
        latch_d    = (latch_q & ~pick_mask) | press_q;
        wr_floor_d = pick_floor;
    end

`ifdef FLOOR_REQ_DEDUP_EN
    logic dup;
    // The staged entry is not yet visible in pending, so it counts as a duplicate too.
    assign dup      = pending[pick_floor] | (wr_vld_q && (wr_floor_q == pick_floor));
    assign wr_vld_d = pick_any & ~dup;
`else
    assign wr_vld_d = pick_any;
`endif

    assign pop    = (count_q != 3'd0) && req_ready;
    assign push   = wr_vld_q;
    assign accept = push && ((count_q != 3'd4) || pop);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_d    = wr_q;
        rd_d    = rd_q;
        ovf_d   = ovf_q;
        if (accept) begin
            mem_d[wr_q] = wr_floor_q;
            wr_d        = wr_q + 2'd1;
        end
        if (pop) begin
            rd_d = rd_q + 2'd1;
        end
        if (push && !accept) begin
            ovf_d = 1'b1;
        end
        count_d = count_q + 3'(accept) - 3'(pop);
    end

    always_comb begin
        pending = 4'b0000;
        for (int j = 0; j < 4; j++) begin
            if (3'(j) < count_q) begin
                pending[mem_q[rd_q + 2'(j)]] = 1'b1;
            end
        end
    end

    assign req_valid = (count_q != 3'd0);
    assign req_floor = mem_q[rd_q];
    assign overflow  = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            press_q    <= '0;
            latch_q    <= '0;
            wr_vld_q   <= 1'b0;
            wr_floor_q <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
                mem_q[i] <= '0;
            end
        end else begin
            sync1_q    <= btn;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            press_q    <= press_d;
            latch_q    <= latch_d;
            wr_vld_q   <= wr_vld_d;
            wr_floor_q <= wr_floor_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_floor_request_queue.sv
// Bench for floor_request_queue: directed scenarios plus random bouncing buttons,
// checked each cycle against a queue-based reference model.
module tb_floor_request_queue;
    localparam int DEB = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;
    logic [1:0] req_floor;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] pending;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [3:0] m_s1, m_s2, m_deb, m_press, m_latch;
    int         m_run [4];
    bit         m_stg_v;
    int         m_stg_f;
    int         m_q [$];
    bit         m_ovf;

    logic [3:0] rb;
    logic [3:0] exp_seq [4];

    floor_request_queue #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .req_floor (req_floor),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_press = '0; m_latch = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_stg_v = 1'b0;
        m_stg_f = 0;
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    // One rising edge of the specified behaviour, using inputs as they stood at the edge.
    task automatic model_edge();
        int  f;
        bit  dup;
        bit  n_stg_v;
        int  n_stg_f;
        logic [3:0] n_press;
        f = -1;
        for (int i = 0; i < 4; i++) if (m_latch[i] && f < 0) f = i;
        n_stg_v = 1'b0;
        n_stg_f = 0;
        if (f >= 0) begin
            dup = 1'b0;
`ifdef FLOOR_REQ_DEDUP_EN
            foreach (m_q[j]) if (m_q[j] == f) dup = 1'b1;
            if (m_stg_v && m_stg_f == f) dup = 1'b1;
`endif
            n_stg_v = !dup;
            n_stg_f = f;
            m_latch[f] = 1'b0;
        end
        m_latch = m_latch | m_press;
        if (m_q.size() != 0 && req_ready) void'(m_q.pop_front());
        if (m_stg_v) begin
            if (m_q.size() < 4) m_q.push_back(m_stg_f);
            else m_ovf = 1'b1;
        end
        m_stg_v = n_stg_v;
        m_stg_f = n_stg_f;
        n_press = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_deb[i]   = m_s2[i];
                    m_run[i]   = 0;
                    n_press[i] = m_s2[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_press = n_press;
        m_s2 = m_s1;
        m_s1 = btn;
    endtask

    task automatic check_all();
        logic [3:0] p;
        p = '0;
        foreach (m_q[j]) p[m_q[j]] = 1'b1;
        chk("valid", {3'b0, req_valid}, 4'(m_q.size() != 0));
        if (m_q.size() != 0) chk("floor", {2'b0, req_floor}, 4'(m_q[0]));
        chk("pending", pending, p);
        chk("overflow", {3'b0, overflow}, {3'b0, m_ovf});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        btn = '0;
        req_ready = 1'b0;
        rb = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {3'b0, req_valid}, 4'd0);
        chk("rst_floor", {2'b0, req_floor}, 4'd0);
        chk("rst_pending", pending, 4'd0);
        chk("rst_overflow", {3'b0, overflow}, 4'd0);
        rst_n = 1'b1;

        // Short glitch on floor 2 never reaches the debounced level
        btn = 4'b0100;
        repeat (3) tick();
        btn = 4'b0000;
        repeat (12) tick();
        chk("glitch_valid", {3'b0, req_valid}, 4'd0);
        chk("glitch_pending", pending, 4'd0);

        // Held floor 1: valid exactly 2+4+3 edges after the button changes
        btn = 4'b0010;
        repeat (8) tick();
        chk("lat_early_valid", {3'b0, req_valid}, 4'd0);
        tick();
        chk("lat_valid", {3'b0, req_valid}, 4'd1);
        chk("lat_floor", {2'b0, req_floor}, 4'd1);
        chk("lat_pending", pending, 4'b0010);
        repeat (5) tick();
        chk("hold_valid", {3'b0, req_valid}, 4'd1);
        chk("hold_floor", {2'b0, req_floor}, 4'd1);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        chk("pop_valid", {3'b0, req_valid}, 4'd0);
        btn = 4'b0000;
        repeat (10) tick();

        // Floors 1 and 3 together drain in ascending order
        req_ready = 1'b1;
        btn = 4'b1010;
        repeat (9) tick();
        chk("pair_first", {2'b0, req_floor}, 4'd1);
        chk("pair_first_v", {3'b0, req_valid}, 4'd1);
        tick();
        chk("pair_second", {2'b0, req_floor}, 4'd3);
        chk("pair_second_v", {3'b0, req_valid}, 4'd1);
        tick();
        chk("pair_empty", {3'b0, req_valid}, 4'd0);
        chk("pair_pending", pending, 4'd0);
        btn = 4'b0000;
        repeat (10) tick();

        // Five presses of floor 0 with no consumer
        req_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            btn = 4'b0001;
            repeat (7) tick();
            btn = 4'b0000;
            repeat (8) tick();
        end
`ifdef FLOOR_REQ_DEDUP_EN
        chk("five_overflow", {3'b0, overflow}, 4'd0);
`else
        chk("five_overflow", {3'b0, overflow}, 4'd1);
`endif
        chk("five_pending", pending, 4'b0001);
        chk("five_floor", {2'b0, req_floor}, 4'd0);

        // Push and pop in the same cycle while full
        btn = 4'b0100;
        repeat (8) tick();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        btn = 4'b0000;
`ifdef FLOOR_REQ_DEDUP_EN
        chk("full_pending", pending, 4'b0100);
        chk("full_floor", {2'b0, req_floor}, 4'd2);
        req_ready = 1'b1;
        tick();
`else
        chk("full_pending", pending, 4'b0101);
        exp_seq[0] = 4'd0; exp_seq[1] = 4'd0; exp_seq[2] = 4'd0; exp_seq[3] = 4'd2;
        req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_floor", {2'b0, req_floor}, exp_seq[i]);
            tick();
        end
        chk("drain_overflow", {3'b0, overflow}, 4'd1);
`endif
        chk("drain_empty", {3'b0, req_valid}, 4'd0);
        repeat (10) tick();

        // Mid-operation reset with three entries queued and floor 0 held
        req_ready = 1'b0;
        btn = 4'b1110;
        repeat (7) tick();
        btn = 4'b0000;
        repeat (8) tick();
        chk("three_pending", pending, 4'b1110);
        btn = 4'b0001;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", {3'b0, req_valid}, 4'd0);
        chk("arst_floor", {2'b0, req_floor}, 4'd0);
        chk("arst_pending", pending, 4'd0);
        chk("arst_overflow", {3'b0, overflow}, 4'd0);
        rst_n = 1'b1;
        repeat (8) tick();
        chk("re_early_valid", {3'b0, req_valid}, 4'd0);
        tick();
        chk("re_valid", {3'b0, req_valid}, 4'd1);
        chk("re_floor", {2'b0, req_floor}, 4'd0);
        chk("re_pending", pending, 4'b0001);
        btn = 4'b0000;
        req_ready = 1'b1;
        repeat (10) tick();

        // Random bouncing buttons and random consumer
        for (int c = 0; c < 1600; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 9) == 0) rb[i] = ~rb[i];
            end
            btn = rb;
            if (c < 800) req_ready = ($urandom_range(0, 3) == 0);
            else req_ready = ($urandom_range(0, 3) != 0);
            if (c == 1000) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
